register_file: RTL and testbench

Parametrised multi-entry register bank for the Hack-16 datapath. It generalises the single load-enabled word register to DEPTH entries, with one write port and two combinational read ports. It adds optional same-cycle write-to-read forwarding, a one-cycle clear of all entries, and a shadow bank for single-cycle context save, restore and swap. It sits between the ALU result bus and the operand muxes of the CPU core.

---
 rtl/hack_pkg.sv | 16 +
 rtl/reg_cell.sv | 18 +
 rtl/register_file.sv | 95 +++++++++
 tb/tb_register_file.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared Hack-16 datapath definitions: word width, default register-file depth
// and the live-bank operation encoding used by the register file.
package hack_pkg;

    localparam int WORD_W        = 16;
    localparam int REGFILE_DEPTH = 8;

    // Live-bank update selected at each edge, highest priority first: CLEAR, RESTORE, WRITE
    typedef enum logic [1:0] {
        NONE    = 2'd0,
        WRITE   = 2'd1,
        CLEAR   = 2'd2,
        RESTORE = 2'd3
    } regfile_op_e;

endpackage

// File: rtl/reg_cell.sv
// One WIDTH-bit storage word with load enable and async active-high reset.
// Next-value selection is done by the parent.
module reg_cell #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/register_file.sv
// DEPTH-entry register bank with one write port, two combinational read ports,
// optional write forwarding, single-cycle clear and a shadow bank for save/restore/swap.
module register_file
    import hack_pkg::*;
#(
    parameter  int WIDTH  = WORD_W,
    parameter  int DEPTH  = REGFILE_DEPTH,
    parameter  bit BYPASS = 1'b1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             clr,
    input  logic             save,
    input  logic             restore,
    output logic             shadow_valid
);

    localparam int            AW1     = AW + 1;
    localparam logic [AW:0]   DEPTH_W = AW1'(DEPTH);

    logic [WIDTH-1:0] live_q   [DEPTH];
    logic [WIDTH-1:0] shadow_q [DEPTH];
    regfile_op_e      op;
    logic             waddr_ok;

    assign waddr_ok = ({1'b0, waddr} < DEPTH_W);

    always_comb begin
        op = NONE;
        if (clr)                          op = CLEAR;
        else if (restore && shadow_valid) op = RESTORE;
        else if (load && waddr_ok)        op = WRITE;
    end

    // Shadow always samples the pre-edge live value, so save+restore is a swap
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic             live_en;
        logic [WIDTH-1:0] live_d;

        assign live_en = (op == CLEAR) || (op == RESTORE) ||
                         ((op == WRITE) && (waddr == AW'(i)));
        assign live_d  = (op == CLEAR)   ? '0 :
                         (op == RESTORE) ? shadow_q[i] : wdata;

        reg_cell #(.WIDTH(WIDTH)) u_live (
            .clk (clk),
            .rst (rst),
            .en  (live_en),
            .d   (live_d),
            .q   (live_q[i])
        );

        reg_cell #(.WIDTH(WIDTH)) u_shadow (
            .clk (clk),
            .rst (rst),
            .en  (save),
            .d   (live_q[i]),
            .q   (shadow_q[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       shadow_valid <= 1'b0;
        else if (save) shadow_valid <= 1'b1;
    end

    // Out-of-range reads return zero; a forward requires a committing in-range write
    logic [AW-1:0]    raddr [2];
    logic [WIDTH-1:0] rdata [2];

    assign raddr[0] = raddr_a;
    assign raddr[1] = raddr_b;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic in_range;
        logic fwd;

        assign in_range = ({1'b0, raddr[p]} < DEPTH_W);
        assign fwd      = BYPASS && (op == WRITE) && (raddr[p] == waddr);
        assign rdata[p] = fwd      ? wdata :
                          in_range ? live_q[raddr[p]] : '0;
    end

    assign rdata_a = rdata[0];
    assign rdata_b = rdata[1];

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench: three instances (DEPTH 8 with and without forwarding, DEPTH 6)
// share one stimulus stream; expectations are queued and checked at the falling edge.
module tb_register_file;
    import hack_pkg::*;

    logic        clk = 1'b0;
    logic        rst, load, clr, save, restore;
    logic [2:0]  waddr, raddr_a, raddr_b;
    logic [15:0] wdata;
    logic [15:0] rda [3];
    logic [15:0] rdb [3];
    logic        sv  [3];

    always #5 clk = ~clk;

    register_file #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b1)) u0 (
        .clk(clk), .rst(rst), .load(load), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rda[0]), .raddr_b(raddr_b), .rdata_b(rdb[0]),
        .clr(clr), .save(save), .restore(restore), .shadow_valid(sv[0]));

    register_file #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b0)) u1 (
        .clk(clk), .rst(rst), .load(load), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rda[1]), .raddr_b(raddr_b), .rdata_b(rdb[1]),
        .clr(clr), .save(save), .restore(restore), .shadow_valid(sv[1]));

    register_file #(.WIDTH(16), .DEPTH(6), .BYPASS(1'b1)) u2 (
        .clk(clk), .rst(rst), .load(load), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rda[2]), .raddr_b(raddr_b), .rdata_b(rdb[2]),
        .clr(clr), .save(save), .restore(restore), .shadow_valid(sv[2]));

    typedef struct {
        string       name;
        int          dut;
        regfile_op_e op;
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string n, input int d, input regfile_op_e op,
                        input logic [15:0] a, input logic [15:0] b, input logic s);
        exp_t e;
        e.name = n; e.dut = d; e.op = op; e.a = a; e.b = b; e.s = s;
        q.push_back(e);
    endtask

    task automatic push01(input string n, input regfile_op_e op,
                          input logic [15:0] a, input logic [15:0] b, input logic s);
        push(n, 0, op, a, b, s);
        push(n, 1, op, a, b, s);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        load = 0; clr = 0; save = 0; restore = 0;
        waddr = 0; wdata = 0; raddr_a = 0; raddr_b = 0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        idle();
        load = 1; waddr = a; wdata = d;
        tick();
    endtask

    // Monitor: outputs are combinational, so compare mid-cycle once inputs are settled
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if (rda[e.dut] !== e.a || rdb[e.dut] !== e.b || sv[e.dut] !== e.s) begin
                    errors++;
                    $display("FAIL %s dut%0d op=%s: got a=%h b=%h sv=%b, expected a=%h b=%h sv=%b",
                             e.name, e.dut, e.op.name(), rda[e.dut], rdb[e.dut], sv[e.dut],
                             e.a, e.b, e.s);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // 1. reset state and reset aborting a write
        rst = 1;
        idle();
        raddr_b = 7;
        push01("reset_read", NONE, 16'h0000, 16'h0000, 1'b0);
        push("reset_read", 2, NONE, 16'h0000, 16'h0000, 1'b0);
        tick();
        rst = 0;
        tick();
        load = 1; waddr = 3; wdata = 16'hBEEF;
        #2 rst = 1;
        tick();
        rst = 0;
        idle();
        raddr_a = 3;
        push01("reset_abort", NONE, 16'h0000, 16'h0000, 1'b0);
        push("reset_abort", 2, NONE, 16'h0000, 16'h0000, 1'b0);
        tick();

        // 2. forwarding vs pre-edge read
        load = 1; waddr = 2; wdata = 16'h1234; raddr_a = 2; raddr_b = 2;
        push("fwd_same_cycle", 0, WRITE, 16'h1234, 16'h1234, 1'b0);
        push("nofwd_same_cycle", 1, WRITE, 16'h0000, 16'h0000, 1'b0);
        tick();
        idle();
        raddr_a = 2; raddr_b = 0;
        push01("write_after_edge", NONE, 16'h1234, 16'h0000, 1'b0);
        push("write_after_edge", 2, NONE, 16'h1234, 16'h0000, 1'b0);
        tick();

        // 3. save / modify / restore
        for (int i = 0; i < 8; i++) wr(3'(i), 16'h0100 + 16'(i));
        idle(); save = 1;
        tick();
        idle(); raddr_a = 0; raddr_b = 7;
        push01("after_save", NONE, 16'h0100, 16'h0107, 1'b1);
        tick();
        wr(3'd5, 16'hFFFF);
        idle(); raddr_a = 5;
        push01("modified", NONE, 16'hFFFF, 16'h0100, 1'b1);
        tick();
        // restore outranks a same-cycle load and suppresses forwarding
        restore = 1; load = 1; waddr = 5; wdata = 16'h9999;
        push01("restore_blocks_fwd", RESTORE, 16'hFFFF, 16'h0100, 1'b1);
        tick();
        idle(); raddr_a = 5; raddr_b = 3;
        push01("restored", NONE, 16'h0105, 16'h0103, 1'b1);
        tick();

        // 4. swap
        for (int i = 0; i < 8; i++) wr(3'(i), 16'h0200 + 16'(i));
        idle(); save = 1; restore = 1;
        tick();
        for (int i = 0; i < 8; i++) begin
            idle(); raddr_a = 3'(i); raddr_b = 3'(7 - i);
            push01("swap_live", NONE, 16'h0100 + 16'(i), 16'h0107 - 16'(i), 1'b1);
            tick();
        end
        idle(); restore = 1;
        tick();
        for (int i = 0; i < 8; i += 3) begin
            idle(); raddr_a = 3'(i); raddr_b = 3'(7 - i);
            push01("swap_shadow", NONE, 16'h0200 + 16'(i), 16'h0207 - 16'(i), 1'b1);
            tick();
        end

        // 5a. clr + load + save
        wr(3'd1, 16'h1111);
        idle(); clr = 1; load = 1; waddr = 1; wdata = 16'hAAAA; save = 1;
        raddr_a = 1; raddr_b = 6;
        push01("clr_no_fwd", CLEAR, 16'h1111, 16'h0206, 1'b1);
        tick();
        idle(); raddr_a = 1; raddr_b = 6;
        push01("cleared", NONE, 16'h0000, 16'h0000, 1'b1);
        tick();
        idle(); restore = 1;
        tick();
        idle(); raddr_a = 1; raddr_b = 6;
        push01("shadow_old_live", NONE, 16'h1111, 16'h0206, 1'b1);
        tick();

        // 5b. restore with no valid shadow falls through to load
        idle();
        rst = 1; #2 rst = 0;
        raddr_a = 1;
        push01("reset_mid_run", NONE, 16'h0000, 16'h0000, 1'b0);
        tick();
        restore = 1; load = 1; waddr = 4; wdata = 16'h5555; raddr_a = 4; raddr_b = 0;
        push("restore_noop_fwd", 0, WRITE, 16'h5555, 16'h0000, 1'b0);
        push("restore_noop_nofwd", 1, WRITE, 16'h0000, 16'h0000, 1'b0);
        tick();
        idle(); raddr_a = 4;
        push01("restore_noop_load", NONE, 16'h5555, 16'h0000, 1'b0);
        tick();

        // 6. out-of-range on the DEPTH=6 instance
        load = 1; waddr = 6; wdata = 16'h7777; raddr_a = 6; raddr_b = 4;
        push("oor_write_fwd", 2, NONE, 16'h0000, 16'h5555, 1'b0);
        push("inrange_fwd", 0, WRITE, 16'h7777, 16'h5555, 1'b0);
        tick();
        for (int i = 0; i < 6; i++) begin
            idle(); raddr_a = 3'(i); raddr_b = 6;
            push("oor_write_dropped", 2, NONE, (i == 4) ? 16'h5555 : 16'h0000, 16'h0000, 1'b0);
            tick();
        end
        load = 1; waddr = 7; wdata = 16'h1357; raddr_a = 7; raddr_b = 7;
        push("oor_read_with_load", 2, NONE, 16'h0000, 16'h0000, 1'b0);
        push("inrange_fwd7", 0, WRITE, 16'h1357, 16'h1357, 1'b0);
        tick();
        idle(); raddr_a = 7; raddr_b = 6;
        push("oor_read", 2, NONE, 16'h0000, 16'h0000, 1'b0);
        push("entry7", 0, NONE, 16'h1357, 16'h7777, 1'b0);
        tick();

        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
